// File: rtl/mdu_pkg.sv
// Shared encodings, FSM states and default latencies for the multiply/divide sequencer.
// Build option MDU_PERF_CNT_EN adds a busy-cycle performance counter to mdu_ctrl.
package mdu_pkg;

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

`ifdef MDU_PERF_CNT_EN
    localparam bit PERF_CNT_EN = 1'b1;
`else
    localparam bit PERF_CNT_EN = 1'b0;
`endif

    typedef enum logic {IDLE, BUSY} state_e;

    // True for the four ops that occupy the unit for several cycles.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: produces the HI/LO pair for an MD op and
// flags a divide by zero so the sequencer can leave HI/LO untouched.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] rs_s;
    logic signed [31:0] dvs_s;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        dvs_u;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic               rt_zero;
    logic               div_ovf;

    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    assign rt_zero = (rt == 32'd0);
    assign div_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

    // Dividing by 1 in the overflow case yields exactly quot=rs, rem=0; it also keeps
    // the divider away from a zero divisor whose result is discarded anyway.
    assign rs_s   = rs;
    assign dvs_s  = (rt_zero | div_ovf) ? 32'sd1 : rt;
    assign quot_s = rs_s / dvs_s;
    assign rem_s  = rs_s % dvs_s;

    assign dvs_u  = rt_zero ? 32'd1 : rt;
    assign quot_u = rs / dvs_u;
    assign rem_u  = rs % dvs_u;

    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = 1'b0;
        case (md_op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_hi   = rem_s;
                res_lo   = quot_s;
                div_zero = rt_zero;
            end
            MD_DIVU: begin
                res_hi   = rem_u;
                res_lo   = quot_u;
                div_zero = rt_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer holding HI/LO and raising a stall while busy.
// Defining MDU_PERF_CNT_EN adds perf_cnt, a wrapping count of busy cycles.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        cancel,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
`ifdef MDU_PERF_CNT_EN
    ,
    output logic [31:0] perf_cnt
`endif
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_e      state;
    state_e      state_next;
    logic [3:0]  count;
    logic [3:0]  count_next;
    logic [31:0] pend_hi;
    logic [31:0] pend_hi_next;
    logic [31:0] pend_lo;
    logic [31:0] pend_lo_next;
    logic        pend_wr;
    logic        pend_wr_next;
    logic [31:0] hi_next;
    logic [31:0] lo_next;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;
    logic        is_md;
    logic        is_mul;

    mdu_calc u_calc (
        .md_op    (md_op),
        .rs       (rs),
        .rt       (rt),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign is_md     = is_md_op(md_op);
    assign is_mul    = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign busy      = (state == BUSY);
    assign stall_req = busy | (start & ~cancel & is_md);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            pend_hi <= pend_hi_next;
            pend_lo <= pend_lo_next;
            pend_wr <= pend_wr_next;
            hi      <= hi_next;
            lo      <= lo_next;
        end
    end

    // The result is captured at the start edge so forwarded operands need not be held;
    // it is only committed to HI/LO when the latency countdown expires.
    always_comb begin
        state_next   = state;
        count_next   = count;
        pend_hi_next = pend_hi;
        pend_lo_next = pend_lo;
        pend_wr_next = pend_wr;
        hi_next      = hi;
        lo_next      = lo;
        case (state)
            IDLE: begin
                if (start && !cancel) begin
                    if (is_md) begin
                        pend_hi_next = res_hi;
                        pend_lo_next = res_lo;
                        pend_wr_next = ~div_zero;
                        count_next   = is_mul ? MULT_N : DIV_N;
                        state_next   = BUSY;
                    end else if (md_op == MD_MTHI) begin
                        hi_next = rs;
                    end else if (md_op == MD_MTLO) begin
                        lo_next = rs;
                    end
                end
            end
            BUSY: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    state_next = IDLE;
                    if (pend_wr) begin
                        hi_next = pend_hi;
                        lo_next = pend_lo;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MDU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt <= 32'd0;
        end else if (busy) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, hand-written corner sequences
// and random traffic, all compared against a latency/arithmetic reference model.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        cancel;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_PERF_CNT_EN
    logic [31:0] perf_cnt;
`endif

    int n_compared;
    int n_mismatched;
    int busy_seen;

    // Reference model: a remaining-latency count and the result waiting to land.
    int          m_left;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_phi;
    logic [31:0] m_plo;
    bit          m_pwr;
    logic [31:0] m_perf;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cncl;
        int          exp_busy;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    mdu_ctrl #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .md_op     (md_op),
        .rs        (rs),
        .rt        (rt),
        .cancel    (cancel),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
`ifdef MDU_PERF_CNT_EN
        ,
        .perf_cnt  (perf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return 64'(ua * ub);
    endfunction

    // Sign-magnitude long division; remainder follows from a = q*b + r.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint          sa;
        longint          sb;
        longint          ma;
        longint          mb;
        longint          qq;
        longint          rr;
        longint unsigned ua;
        longint unsigned ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            qq = ma / mb;
            if ((sa < 0) != (sb < 0)) qq = -qq;
            rr = sa - qq * sb;
            return {rr[31:0], qq[31:0]};
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        qq = longint'(ua / ub);
        rr = longint'(ua - (ua / ub) * ub);
        return {rr[31:0], qq[31:0]};
    endfunction

    task automatic model_reset();
        m_left = 0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        m_phi  = 32'd0;
        m_plo  = 32'd0;
        m_pwr  = 1'b0;
        m_perf = 32'd0;
    endtask

    task automatic model_edge(input logic s, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic c);
        logic [63:0] r;
        if (m_left > 0) begin
            m_perf = m_perf + 32'd1;
            m_left = m_left - 1;
            if (m_left == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (s && !c) begin
            case (op)
                3'd1, 3'd2: begin
                    r = ref_mult(a, b, op == 3'd1);
                    {m_phi, m_plo} = r;
                    m_pwr  = 1'b1;
                    m_left = MC;
                end
                3'd3, 3'd4: begin
                    m_pwr = (b != 32'd0);
                    if (m_pwr) begin
                        r = ref_div(a, b, op == 3'd3);
                        {m_phi, m_plo} = r;
                    end
                    m_left = DC;
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check the combinational stall,
    // then check registered outputs just after the rising edge.
    task automatic apply_stimulus(input logic s, input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic c);
        bit exp_stall;
        @(negedge clk);
        start  = s;
        md_op  = op;
        rs     = a;
        rt     = b;
        cancel = c;
        #1;
        exp_stall = (m_left > 0) || (s && !c && op >= 3'd1 && op <= 3'd4);
        check_output("stall_req", 32'(stall_req), 32'(exp_stall));
        @(posedge clk);
        model_edge(s, op, a, b, c);
        #1;
        if (busy) busy_seen++;
        check_output("busy", 32'(busy), 32'(m_left > 0));
        check_output("hi", hi, m_hi);
        check_output("lo", lo, m_lo);
`ifdef MDU_PERF_CNT_EN
        check_output("perf_cnt", perf_cnt, m_perf);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        busy_seen    = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        md_op  = 3'd0;
        rs     = 32'd0;
        rt     = 32'd0;
        cancel = 1'b0;
        model_reset();
        $display("[TB] perf counter build option: %0d", mdu_pkg::PERF_CNT_EN);

        @(posedge clk);
        #1;
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset stall_req", 32'(stall_req), 32'd0);
        check_output("reset hi", hi, 32'd0);
        check_output("reset lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{3'd1, 32'hFFFF_FFFD, 32'd7,         1'b0, MC, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,         1'b0, MC, 32'h0000_0001, 32'hFFFF_FFFE});
        vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'd2,         1'b0, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{3'd4, 32'd5,         32'd0,         1'b0, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{3'd5, 32'h1234_5678, 32'd0,         1'b0, 0,  32'h1234_5678, 32'hFFFF_FFFD});
        vecs.push_back('{3'd6, 32'h9ABC_DEF0, 32'd0,         1'b0, 0,  32'h1234_5678, 32'h9ABC_DEF0});
        vecs.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DC, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{3'd1, 32'd5,         32'd5,         1'b1, 0,  32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{3'd7, 32'd9,         32'd9,         1'b0, 0,  32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{3'd0, 32'd9,         32'd9,         1'b0, 0,  32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{3'd3, 32'd7,         32'hFFFF_FFFE, 1'b0, DC, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back('{3'd4, 32'd100,       32'd7,         1'b0, DC, 32'h0000_0002, 32'h0000_000E});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MC, 32'h0000_0000, 32'h0000_0001});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MC, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, MC, 32'h4000_0000, 32'h0000_0000});

        foreach (vecs[k]) begin
            busy_seen = 0;
            apply_stimulus(1'b1, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].cncl);
            idle(DC + 1);
            check_output($sformatf("vec%0d busy cycles", k), 32'(busy_seen), 32'(vecs[k].exp_busy));
            check_output($sformatf("vec%0d hi", k), hi, vecs[k].exp_hi);
            check_output($sformatf("vec%0d lo", k), lo, vecs[k].exp_lo);
        end

        // A second mult offered while busy must be dropped and not disturb the first.
        apply_stimulus(1'b1, 3'd1, 32'd2, 32'd3, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 3'd1, 32'd100, 32'd100, 1'b0);
        apply_stimulus(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
        idle(MC + 1);
        check_output("ignored-start hi", hi, 32'd0);
        check_output("ignored-start lo", lo, 32'd6);

        // Back-to-back: a new op is accepted in the very cycle the previous result lands.
        apply_stimulus(1'b1, 3'd1, 32'd4, 32'd5, 1'b0);
        idle(MC);
        check_output("b2b first lo", lo, 32'd20);
        check_output("b2b idle busy", 32'(busy), 32'd0);
        apply_stimulus(1'b1, 3'd2, 32'd6, 32'd7, 1'b0);
        idle(MC);
        check_output("b2b second lo", lo, 32'd42);

        // Reset in the third busy cycle of a divide discards the pending result.
        apply_stimulus(1'b1, 3'd3, 32'd100, 32'd3, 1'b0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_output("midop reset busy", 32'(busy), 32'd0);
        check_output("midop reset hi", hi, 32'd0);
        check_output("midop reset lo", lo, 32'd0);
`ifdef MDU_PERF_CNT_EN
        check_output("midop reset perf_cnt", perf_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle(DC + 2);
        check_output("post reset lo", lo, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic        s;
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic        c;
            s  = ($urandom_range(0, 9) < 4);
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            c = ($urandom_range(0, 4) == 0);
            apply_stimulus(s, op, a, b, c);
        end
        idle(DC + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
